ps2_frame_rx: RTL

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_frame_rx_pkg.sv | 16 +
 rtl/ps2_frame_rx_input_filter.sv | 46 ++++
 rtl/ps2_frame_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ps2_frame_rx_pkg.sv
// Shared types for the PS/2 receive path and the machine configuration.
package ps2_frame_rx_pkg;

  typedef enum logic [1:0] {MACHINE_48K, MACHINE_128K, MACHINE_PENTAGON} machine_t;
  typedef enum logic [1:0] {TURBO_OFF, TURBO_2X, TURBO_4X} turbo_t;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

  localparam int unsigned FIFO_DEPTH = 4;

  // True when data plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx_input_filter.sv
// Two-flop synchronizer followed by a stability filter; idles high out of reset.
module ps2_input_filter #(
  parameter int unsigned FILTER_LEN = 16
) (
  input  logic clk28,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q tracks how many consecutive synchronized samples disagree with filt_q.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: filtered inputs, frame FSM with timeout, 4-entry scancode FIFO.
module ps2_frame_rx
  import ps2_frame_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 28_000_000,
  parameter int unsigned FILTER_LEN = 16,
  parameter int unsigned TIMEOUT_US = 100
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);

  localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);

  logic ps2_clk_f, ps2_dat_f, fall;
  logic clk_prev_q, clk_prev_d;

  ps2_frame_rx_pkg::ps2_rx_state_t state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_parity_q, err_parity_d;
  logic            err_frame_q, err_frame_d;
  logic            push;

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       overflow_q, overflow_d;
  logic       pop, full, push_ok;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk28 (clk28),
    .rst   (rst),
    .din   (ps2_clk_in),
    .dout  (ps2_clk_f)
  );

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk28 (clk28),
    .rst   (rst),
    .din   (ps2_dat_in),
    .dout  (ps2_dat_f)
  );

  assign fall = clk_prev_q & ~ps2_clk_f;

  always_comb begin
    clk_prev_d   = ps2_clk_f;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    to_cnt_d     = (state_q == IDLE) ? '0 : to_cnt_q + TO_W'(1);
    err_parity_d = 1'b0;
    err_frame_d  = 1'b0;
    push         = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!ps2_dat_f) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            err_frame_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {ps2_dat_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = ps2_dat_f;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!ps2_dat_f)                          err_frame_d  = 1'b1;
          else if (odd_parity_ok(shift_q, parity_q)) push         = 1'b1;
          else                                     err_parity_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
      state_d     = IDLE;
      err_frame_d = 1'b1;
      to_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      clk_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      err_parity_q <= err_parity_d;
      err_frame_q  <= err_frame_d;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop     = code_ready && (count_q != 3'd0);
  assign full    = (count_q == 3'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push_ok && !pop)      count_d = count_q + 3'd1;
    else if (!push_ok && pop) count_d = count_q - 3'd1;
    if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign code       = mem_q[rd_ptr_q];
  assign code_valid = (count_q != 3'd0);
  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;
  assign overflow   = overflow_q;

endmodule
